// File: rtl/qosc_pkg.sv
// qosc_pkg: shared widths, state encoding, gain constant and arctangent table for the IQ detector
package qosc_pkg;
    localparam int SAMPLE_W = 16;
    localparam int XY_W     = 18;
    localparam int GAIN_INV = 19898;
    localparam logic [SAMPLE_W-1:0] ATAN_TAB [16] = '{
        16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163, 16'd81,
        16'd41,   16'd20,   16'd10,   16'd5,    16'd3,   16'd1,   16'd1,   16'd0
    };
    typedef enum logic [1:0] {IDLE, ROTATE, COMP, DONE} state_t;
    function automatic logic [SAMPLE_W-1:0] atan_lut(input logic [3:0] k);
        return ATAN_TAB[k];
    endfunction
endpackage

// File: rtl/qosc_cordic_stage.sv
// qosc_cordic_stage: one combinational CORDIC vectoring micro-rotation selected by k
module qosc_cordic_stage
    import qosc_pkg::*;
(
    input  logic signed [XY_W-1:0]     x_in,
    input  logic signed [XY_W-1:0]     y_in,
    input  logic        [SAMPLE_W-1:0] z_in,
    input  logic        [3:0]          k,
    output logic signed [XY_W-1:0]     x_out,
    output logic signed [XY_W-1:0]     y_out,
    output logic        [SAMPLE_W-1:0] z_out
);
    logic signed [XY_W-1:0] xs, ys;
    logic [SAMPLE_W-1:0] a;
    // rotate toward the x axis; direction chosen by the sign of y, using pre-rotation x and y
    always_comb begin
        xs    = x_in >>> k;
        ys    = y_in >>> k;
        a     = atan_lut(k);
        x_out = y_in[XY_W-1] ? x_in - ys : x_in + ys;
        y_out = y_in[XY_W-1] ? y_in + xs : y_in - xs;
        z_out = y_in[XY_W-1] ? z_in - a : z_in + a;
    end
endmodule

// File: rtl/qosc_iq_detector.sv
// qosc_iq_detector: CORDIC magnitude/phase detector for oscillator I/Q samples; define QOSC_IQ_GAIN_COMP_EN to scale mag by 1/K
module qosc_iq_detector
    import qosc_pkg::*;
#(
    parameter int ITER = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [SAMPLE_W-1:0] i_in,
    input  logic signed [SAMPLE_W-1:0] q_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic        [SAMPLE_W-1:0] mag,
    output logic signed [SAMPLE_W-1:0] phase
);
    state_t state_q, state_d;
    logic [4:0] k_q, k_d;
    logic signed [XY_W-1:0] x_q, x_d, y_q, y_d, xn, yn, ix, qx;
    logic [SAMPLE_W-1:0] z_q, z_d, zn, mag_q, mag_d;
    logic signed [SAMPLE_W-1:0] phase_q, phase_d;
    logic zero_q, zero_d, in_ready_q, in_ready_d, out_valid_q, out_valid_d;

    function automatic logic [SAMPLE_W-1:0] sat(input logic signed [XY_W-1:0] v);
        return v[XY_W-1] ? '0 : (v[XY_W-2] ? '1 : v[SAMPLE_W-1:0]);
    endfunction

    qosc_cordic_stage u_stage (
        .x_in (x_q),
        .y_in (y_q),
        .z_in (z_q),
        .k    (k_q[3:0]),
        .x_out(xn),
        .y_out(yn),
        .z_out(zn)
    );

`ifdef QOSC_IQ_GAIN_COMP_EN
    logic signed [35:0] prod;
    assign prod = 36'(x_q) * 36'(GAIN_INV);
`endif

    assign ix = XY_W'(i_in);
    assign qx = XY_W'(q_in);

    // next-state logic: accept, iterate, optionally compensate, then hold the result until taken
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        zero_d  = zero_q;
        mag_d   = mag_q;
        phase_d = phase_q;
        case (state_q)
            IDLE: if (in_valid && in_ready_q) begin
                x_d     = i_in[SAMPLE_W-1] ? -ix : ix;
                y_d     = i_in[SAMPLE_W-1] ? -qx : qx;
                z_d     = i_in[SAMPLE_W-1] ? 16'h8000 : 16'h0000;
                zero_d  = (i_in == 0) && (q_in == 0);
                k_d     = '0;
                state_d = ROTATE;
            end
            ROTATE: if (k_q == 5'(ITER)) begin
`ifdef QOSC_IQ_GAIN_COMP_EN
                x_d     = XY_W'(prod >>> 15);
                state_d = COMP;
`else
                mag_d   = sat(x_q);
                phase_d = zero_q ? '0 : z_q;
                state_d = DONE;
`endif
            end else begin
                x_d = xn;
                y_d = yn;
                z_d = zn;
                k_d = k_q + 5'd1;
            end
            COMP: begin
                mag_d   = sat(x_q);
                phase_d = zero_q ? '0 : z_q;
                state_d = DONE;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        in_ready_d  = state_d == IDLE;
        out_valid_d = state_d == DONE;
    end

    // state and registered handshake outputs; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            zero_q      <= 1'b0;
            mag_q       <= '0;
            phase_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            zero_q      <= zero_d;
            mag_q       <= mag_d;
            phase_q     <= phase_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign mag       = mag_q;
    assign phase     = phase_q;
endmodule

// File: tb/tb_qosc_iq_detector.sv
// tb_qosc_iq_detector: directed vector table, stall/reset sequences and random samples against an atan2 model
module tb_qosc_iq_detector;
    localparam int  ITER = 16;
    localparam real KG   = 1.6467602581210654;
    localparam real PI   = 3.14159265358979324;
`ifdef QOSC_IQ_GAIN_COMP_EN
    localparam int  LAT  = ITER + 2;
    localparam bit  COMP = 1'b1;
`else
    localparam int  LAT  = ITER + 1;
    localparam bit  COMP = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid;
    logic signed [15:0] i_in = '0, q_in = '0;
    logic [15:0] mag;
    logic signed [15:0] phase;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    qosc_iq_detector #(.ITER(ITER)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .i_in     (i_in),
        .q_in     (q_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .mag      (mag),
        .phase    (phase)
    );

    typedef struct {int i; int q; int ph; int ph_tol; int mg; int mg_tol;} vec_t;

    task automatic chk(input string name, input int act, input int exp, input int tol, input bit wrap);
        int d;
        d = act - exp;
        if (wrap) d = (((d + 32768) % 65536) + 65536) % 65536 - 32768;
        checks++;
        if (d > tol || d < -tol) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d tol=%0d", name, act, exp, tol);
        end
    endtask

    function automatic int model_phase(input int i, input int q);
        real a;
        int r;
        if (i == 0 && q == 0) return 0;
        a = $atan2(real'(q), real'(i)) * 32768.0 / PI;
        r = $rtoi($floor(a + 0.5));
        return (r >= 32768) ? r - 65536 : r;
    endfunction

    function automatic int model_mag(input int i, input int q);
        real r;
        r = $sqrt(real'(i) * real'(i) + real'(q) * real'(q));
        if (!COMP) r = r * KG;
        return (r > 65535.0) ? 65535 : $rtoi($floor(r + 0.5));
    endfunction

    // one transaction; hold>0 keeps out_ready low that many cycles while probing stability
    task automatic run_sample(input int si, input int sq, input int hold,
                              output int om, output int op, output int lat, output bit ok);
        int n;
        ok = 0; om = 0; op = 0; lat = 0; n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!in_ready) return;
        i_in = 16'(si); q_in = 16'(sq); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; i_in = 16'($urandom); q_in = 16'($urandom);
        while (lat < 60) begin
            @(posedge clk); #1; lat++;
            if (out_valid) break;
        end
        if (!out_valid) return;
        ok = 1; om = int'(mag); op = int'(phase);
        for (int c = 0; c < hold; c++) begin
            in_valid = 1'b1; i_in = 16'($urandom); q_in = 16'($urandom);
            @(posedge clk); #1;
            chk("hold_stable", int'(out_valid && !in_ready && int'(mag) == om && int'(phase) == op), 1, 0, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (hold > 0) begin
            chk("release_no_accept", int'(in_ready && !out_valid), 1, 0, 0);
            in_valid = 1'b0;
        end
    endtask

    initial begin
        vec_t vecs[6];
        int om, op, lat, si, sq, n;
        bit ok;
        vecs[0] = '{16384, 0, 0, 2, COMP ? 16384 : 26981, COMP ? 4 : 8};
        vecs[1] = '{0, 16384, 16384, 2, COMP ? 16384 : 26981, COMP ? 4 : 8};
        vecs[2] = '{-16384, 0, -32768, 2, COMP ? 16384 : 26981, COMP ? 4 : 8};
        vecs[3] = '{0, -16384, -16384, 2, COMP ? 16384 : 26981, COMP ? 4 : 8};
        vecs[4] = '{-32768, -32768, -24576, 2, COMP ? 46341 : 65535, COMP ? 8 : 0};
        vecs[5] = '{0, 0, 0, 0, 0, 0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs_zero", int'({in_ready, out_valid}) + int'(mag) + int'(phase), 0, 0, 0);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("in_ready_before_edge", int'(in_ready), 0, 0, 0);
        @(posedge clk); #1;
        chk("in_ready_first_edge", int'(in_ready), 1, 0, 0);

        for (int v = 0; v < 6; v++) begin
            run_sample(vecs[v].i, vecs[v].q, 0, om, op, lat, ok);
            chk($sformatf("vec%0d_done", v), int'(ok), 1, 0, 0);
            chk($sformatf("vec%0d_latency", v), lat, LAT, 0, 0);
            chk($sformatf("vec%0d_phase", v), op, vecs[v].ph, vecs[v].ph_tol, 1);
            chk($sformatf("vec%0d_mag", v), om, vecs[v].mg, vecs[v].mg_tol, 0);
        end

        run_sample(16384, 16384, 10, om, op, lat, ok);
        chk("stall_done", int'(ok), 1, 0, 0);
        chk("stall_phase", op, 8192, 3, 1);

        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        i_in = 16'sd16384; q_in = 16'sd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", int'({in_ready, out_valid}) + int'(mag) + int'(phase), 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_release_in_ready_low", int'(in_ready), 0, 0, 0);
        @(posedge clk); #1;
        chk("rst_release_in_ready_high", int'(in_ready), 1, 0, 0);
        n = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (out_valid) n++;
        end
        chk("no_result_after_abort", n, 0, 0, 0);

        for (int r = 0; r < 100; r++) begin
            do begin
                si = int'($urandom_range(0, 65535)) - 32768;
                sq = int'($urandom_range(0, 65535)) - 32768;
            end while (real'(si) * real'(si) + real'(sq) * real'(sq) < 16384.0 * 16384.0);
            run_sample(si, sq, 0, om, op, lat, ok);
            if (!ok) chk($sformatf("rand%0d_done", r), 0, 1, 0, 0);
            chk($sformatf("rand%0d_phase i=%0d q=%0d", r, si, sq), op, model_phase(si, sq), 3, 1);
            chk($sformatf("rand%0d_mag i=%0d q=%0d", r, si, sq), om, model_mag(si, sq), 16, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/qosc_iq_detector.md
QOSC_IQ_DETECTOR -- requirements
Module: qosc_iq_detector

Interface
REQ-001 Parameter: ITER, default 16, number of CORDIC vectoring iterations (1..16).
REQ-002 Port: clk  input  1  sole clock, rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: in_valid  input  1  I/Q sample present.
REQ-005 Port: in_ready  output  1  block accepts a sample this cycle.
REQ-006 Port: i_in  input  16  signed Q15 in-phase sample (oscillator real output).
REQ-007 Port: q_in  input  16  signed Q15 quadrature sample (oscillator imaginary output).
REQ-008 Port: out_valid  output  1  result present.
REQ-009 Port: out_ready  input  1  consumer takes result.
REQ-010 Port: mag  output  16  unsigned magnitude.
REQ-011 Port: phase  output  16  signed angle, 32768 counts per pi, 0x8000 = -pi.

Function
REQ-012 FSM states IDLE, ROTATE, DONE; in_ready SHALL be 1 only in IDLE, out_valid 1 only in DONE, both registered.
REQ-013 IDLE: in_valid&in_ready at edge N latches sample, performs pre-rotation, moves to ROTATE with iteration counter k=0.
REQ-014 Pre-rotation: if i_in<0 then x=-i_in, y=-q_in, z=-32768; else x=i_in, y=q_in, z=0.
REQ-015 x,y datapath 18-bit signed (absorbs negation of -32768 and CORDIC gain 1.6468); z 16-bit, wraps modulo 2^16.
REQ-016 ROTATE, one iteration per clock: if y>=0 then x+=y>>>k, y-=x>>>k, z+=ATAN[k]; else x-=y>>>k, y+=x>>>k, z-=ATAN[k]; updates use pre-iteration x,y.
REQ-017 After iteration k=ITER-1, move to DONE; out_valid first asserted at edge N+ITER+1.
REQ-018 DONE: mag, phase, out_valid held stable until out_ready=1; that edge returns to IDLE; no sample accepted in same edge.
REQ-019 phase = final z; mag = final x (or compensated value, REQ-025), saturated to 65535, never negative.
REQ-020 Zero input (i_in=0, q_in=0) SHALL yield mag=0, phase=0.
REQ-021 in_valid outside IDLE ignored; i_in/q_in changes after acceptance have no effect.

Reset
REQ-022 rst_n low SHALL immediately force state IDLE, k=0, in_ready=0, out_valid=0, mag=0, phase=0, internal x,y,z=0.
REQ-023 Reset mid-ROTATE or mid-DONE aborts the transaction; no result is ever emitted for it.
REQ-024 in_ready SHALL rise on first clock edge after rst_n deasserts.

Configuration
REQ-025 Macro QOSC_IQ_GAIN_COMP_EN defined: mag = (x*19898)>>>15 (1/K in Q15), one extra cycle so out_valid at N+ITER+2; undefined: mag = raw x (gain 1.6468), latency N+ITER+1.

Structure
REQ-026 Package qosc_pkg SHALL hold ATAN table {8192,4836,2555,1297,651,326,163,81,41,20,10,5,3,1,1,0}, gain constant 19898, state enum, sample width 16.
REQ-027 One sub-module qosc_cordic_stage: combinational single micro-rotation (x,y,z,k in -> x,y,z out), instantiated once, driven by k.

Verification
REQ-028 i=16384,q=0 -> phase 0 +/-2; mag 26981 +/-8 (no comp) or 16384 +/-4 (comp); out_valid at N+17 (no comp).
REQ-029 i=0,q=16384 -> phase 16384 +/-2; i=-16384,q=0 -> phase -32768 +/-2 (0x8000 or 0x7FFE..0x7FFF).
REQ-030 i=-32768,q=-32768 -> phase -24576 +/-2; mag 65535 saturated (no comp) or 46341 +/-8 (comp).
REQ-031 out_ready held 0 for 10 cycles in DONE -> out_valid, mag, phase stable, in_ready 0, new in_valid ignored.
REQ-032 rst_n pulsed low at k=5 -> all outputs 0 during reset, no out_valid afterward, in_ready 1 one edge after release.
REQ-033 i=0,q=0 -> mag 0, phase 0; back-to-back 100 random samples vs. atan2 model within +/-3 counts.
